// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: per-stage enable/flush/bubble from branch, load-use and memory-busy; optional stats via HAZARD_STATS_EN.
// Latency: controls are combinational from registered state and current inputs (zero cycle); state, watchdog and counters are registered.
// Backpressure: mem_busy freezes every stage and outranks branch and load-use, which upstream holds until the first unfrozen cycle.
module hazard_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MAX_MEM_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_taken,
  input  logic        ld_use,
  input  logic        mem_busy,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_en,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_LU_HOLD  = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_LIMIT   = 8'(MAX_MEM_WAIT);
  localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

  state_t     state_q, state_d;
  state_t     saved_q, saved_d;
  state_t     eff_state;
  logic [2:0] fcnt_q, fcnt_d;
  logic [7:0] wait_q, wait_d;
  logic       to_q, to_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      saved_q <= ST_RUN;
      fcnt_q  <= '0;
      wait_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      fcnt_q  <= fcnt_d;
      wait_q  <= wait_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    fcnt_d      = fcnt_q;
    wait_d      = wait_q;
    to_d        = to_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    // While waiting on memory the saved state drives decisions, so exit is Mealy in that state.
    eff_state   = (state_q == ST_MEM_WAIT) ? saved_q : state_q;

    if (mem_busy) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      exmem_en = 1'b0;
      state_d  = ST_MEM_WAIT;
      saved_d  = eff_state;
      wait_d   = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
      if (wait_d >= WAIT_LIMIT) begin
        to_d = 1'b1;
      end
    end else begin
      wait_d  = '0;
      state_d = ST_RUN;
      if (br_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (MULTI_FLUSH) begin
          state_d = ST_FLUSH;
          fcnt_d  = FLUSH_RELOAD;
        end
      end else begin
        case (eff_state)
          ST_FLUSH: begin
            ifid_flush = 1'b1;
            fcnt_d     = (fcnt_q == 3'd0) ? 3'd0 : fcnt_q - 3'd1;
            state_d    = (fcnt_q <= 3'd1) ? ST_RUN : ST_FLUSH;
          end
          ST_RUN: begin
            if (ld_use) begin
              pc_en       = 1'b0;
              ifid_en     = 1'b0;
              idex_bubble = 1'b1;
              state_d     = ST_LU_HOLD;
            end
          end
          default: begin
            state_d = ST_RUN;
          end
        endcase
      end
    end

    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  assign mem_timeout = to_q & ~rst;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;
  logic        br_honoured;

  assign br_honoured = br_taken & ~mem_busy & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && stall_q != 16'hFFFF) begin
        stall_q <= stall_q + 16'd1;
      end
      if (br_honoured && flush_q != 16'hFFFF) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

  assign stall_cnt = rst ? 16'h0000 : stall_q;
  assign flush_cnt = rst ? 16'h0000 : flush_q;
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed vector table for the multi-cycle corner cases, then random traffic against a cost-based model.
module tb_hazard_sequencer;

  localparam int FC = 3;
  localparam int MW = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br_taken = 1'b0;
  logic        ld_use = 1'b0;
  logic        mem_busy = 1'b0;
  logic        pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Model: remaining flush cycles owed, whether the last issue cycle was a load-use stall, frozen run length.
  int m_flush_left = 0;
  int m_frozen     = 0;
  bit m_lu_block   = 1'b0;
  bit m_to         = 1'b0;
  int m_stall      = 0;
  int m_flush_ev   = 0;

  hazard_sequencer #(.FLUSH_CYCLES(FC), .MAX_MEM_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .br_taken(br_taken), .ld_use(ld_use), .mem_busy(mem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_en(exmem_en), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         r, b, l, m;
    logic [4:0] ctl;
    bit         to;
  } vec_t;

  vec_t tbl[$];

  localparam logic [4:0] C_RST = 5'b00110;
  localparam logic [4:0] C_RUN = 5'b11001;
  localparam logic [4:0] C_BR  = 5'b11111;
  localparam logic [4:0] C_FL  = 5'b11101;
  localparam logic [4:0] C_LU  = 5'b00011;
  localparam logic [4:0] C_FRZ = 5'b00000;

  task automatic addv(input bit r, b, l, m, input logic [4:0] ctl, input bit to);
    vec_t v;
    v.r = r; v.b = b; v.l = l; v.m = m; v.ctl = ctl; v.to = to;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit r, b, l, m, input bit tab, input logic [4:0] t_ctl, input bit t_to,
                      input string tag);
    logic [4:0]  e_ctl;
    bit          e_to;
    logic [15:0] e_stall, e_flush;
    @(negedge clk);
    rst = r; br_taken = b; ld_use = l; mem_busy = m;
    #1;
    e_to = r ? 1'b0 : m_to;
`ifdef HAZARD_STATS_EN
    e_stall = r ? 16'h0 : 16'(m_stall);
    e_flush = r ? 16'h0 : 16'(m_flush_ev);
`else
    e_stall = 16'h0;
    e_flush = 16'h0;
`endif
    if (r) begin
      e_ctl = C_RST;
      m_flush_left = 0; m_frozen = 0; m_lu_block = 1'b0; m_to = 1'b0;
      m_stall = 0; m_flush_ev = 0;
    end else if (m) begin
      e_ctl = C_FRZ;
      m_frozen++;
      if (m_frozen >= MW) m_to = 1'b1;
      if (m_stall < 65535) m_stall++;
    end else begin
      m_frozen = 0;
      if (b) begin
        e_ctl = C_BR;
        m_flush_left = FC - 1;
        m_lu_block = 1'b0;
        if (m_flush_ev < 65535) m_flush_ev++;
      end else if (m_flush_left > 0) begin
        e_ctl = C_FL;
        m_flush_left--;
      end else if (l && !m_lu_block) begin
        e_ctl = C_LU;
        m_lu_block = 1'b1;
        if (m_stall < 65535) m_stall++;
      end else begin
        e_ctl = C_RUN;
        m_lu_block = 1'b0;
      end
    end
    check({tag, "_ctl"}, 32'({pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en}), 32'(e_ctl));
    check({tag, "_timeout"}, 32'(mem_timeout), 32'(e_to));
    check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(e_stall));
    check({tag, "_flush_cnt"}, 32'(flush_cnt), 32'(e_flush));
    if (tab) begin
      check({tag, "_ctl_tbl"}, 32'({pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en}), 32'(t_ctl));
      check({tag, "_timeout_tbl"}, 32'(mem_timeout), 32'(t_to));
    end
  endtask

  initial begin
    int busy_left;
    bit rb, rl, rm, rr;

    // reset with noisy inputs, then idle
    addv(1, 1, 0, 1, C_RST, 0);
    addv(1, 0, 1, 0, C_RST, 0);
    addv(1, 1, 1, 1, C_RST, 0);
    addv(0, 0, 0, 0, C_RUN, 0);
    // branch: three flush cycles, one bubble
    addv(0, 1, 0, 0, C_BR,  0);
    addv(0, 0, 0, 0, C_FL,  0);
    addv(0, 0, 0, 0, C_FL,  0);
    addv(0, 0, 0, 0, C_RUN, 0);
    // load-use held two cycles costs one bubble
    addv(0, 0, 1, 0, C_LU,  0);
    addv(0, 0, 1, 0, C_RUN, 0);
    addv(0, 0, 0, 0, C_RUN, 0);
    // branch and load-use together, load-use ignored in flush
    addv(0, 1, 1, 0, C_BR,  0);
    addv(0, 0, 1, 0, C_FL,  0);
    addv(0, 0, 0, 0, C_FL,  0);
    addv(0, 0, 0, 0, C_RUN, 0);
    // freeze mid-flush with counter at 1
    addv(0, 1, 0, 0, C_BR,  0);
    addv(0, 0, 0, 0, C_FL,  0);
    for (int i = 0; i < 5; i++) addv(0, 0, 0, 1, C_FRZ, 0);
    addv(0, 0, 0, 0, C_FL,  0);
    addv(0, 0, 0, 0, C_RUN, 0);
    // branch honoured in LU_HOLD
    addv(0, 0, 1, 0, C_LU,  0);
    addv(0, 1, 0, 0, C_BR,  0);
    addv(0, 0, 0, 0, C_FL,  0);
    addv(0, 0, 0, 0, C_FL,  0);
    addv(0, 0, 0, 0, C_RUN, 0);
    // freeze inside LU_HOLD resumes LU_HOLD
    addv(0, 0, 1, 0, C_LU,  0);
    addv(0, 0, 1, 1, C_FRZ, 0);
    addv(0, 0, 1, 0, C_RUN, 0);
    addv(0, 0, 1, 0, C_LU,  0);
    addv(0, 0, 0, 0, C_RUN, 0);
    // watchdog: 20 frozen cycles, flag visible from the 16th
    for (int i = 1; i <= 20; i++) addv(0, 0, 0, 1, C_FRZ, (i >= MW + 1));
    addv(0, 0, 0, 0, C_RUN, 1);
    addv(1, 0, 0, 1, C_RST, 0);
    addv(0, 0, 0, 0, C_RUN, 0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].b, tbl[i].l, tbl[i].m, 1'b1, tbl[i].ctl, tbl[i].to,
           $sformatf("vec%0d", i));
    end

    busy_left = 0;
    for (int c = 0; c < 4000; c++) begin
      rr = ($urandom_range(0, 199) == 0);
      if (busy_left == 0 && $urandom_range(0, 9) == 0) busy_left = $urandom_range(1, 20);
      rm = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      rb = ($urandom_range(0, 5) == 0);
      rl = ($urandom_range(0, 3) == 0);
      step(rr, rb, rl, rm, 1'b0, 5'b0, 1'b0, $sformatf("rnd%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
